// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared encodings and lane helpers for the dm_pipe data memory
package dm_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         SZ_B:    byte_en = 4'b0001 << lane;
         SZ_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
         SZ_W:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] lane, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         SZ_B:    load_extract = sgn ? {{24{b[7]}}, b} : {24'b0, b};
         SZ_H:    load_extract = sgn ? {{16{h[15]}}, h} : {16'b0, h};
         default: load_extract = word;
      endcase
   endfunction

endpackage

// File: rtl/dm_rsp_pipe.sv
// rtl/dm_rsp_pipe.sv - RD_LAT-deep response delay line of {valid, err, rdata}
module dm_rsp_pipe #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cap_valid,
   input  logic        cap_err,
   input  logic [31:0] cap_rdata,
   output logic        rsp_valid,
   output logic        rsp_err,
   output logic [31:0] rsp_rdata
);

   logic [33:0] stage [RD_LAT];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < RD_LAT; i++) stage[i] <= '0;
      end else begin
         stage[0] <= {cap_valid, cap_err, cap_rdata};
         for (int i = 1; i < RD_LAT; i++) stage[i] <= stage[i-1];
      end
   end

   assign {rsp_valid, rsp_err, rsp_rdata} = stage[RD_LAT-1];

endmodule

// File: rtl/dm_pipe.sv
// rtl/dm_pipe.sv - pipelined data memory with clear FSM, range/alignment errors; DM_TRACE_EN prints stores
module dm_pipe
   import dm_pkg::*;
#(
   parameter int          WORDS     = 4096,
   parameter int          RD_LAT    = 1,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [31:0] req_pc,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        init_busy
);

   localparam int AW = $clog2(WORDS);

   logic [31:0]   mem [WORDS];
   logic [0:0]    state;
   logic [AW-1:0] clr_idx;

   logic [31:0]   off;
   logic [AW-1:0] idx;
   logic [1:0]    lane;
   logic          err;
   logic          acc;
   logic [3:0]    be;
   logic [31:0]   bit_mask;
   logic [31:0]   wpos;
   logic [31:0]   cur;
   logic [31:0]   merged;
   logic [31:0]   ld;

   assign off  = req_addr - BASE_ADDR;
   assign idx  = off[AW+1:2];
   assign lane = off[1:0];

   // Addresses below BASE_ADDR wrap to a huge offset and fail the range test.
   assign err = (req_size == 2'd3) ||
                (req_size == SZ_H && lane[0]) ||
                (req_size == SZ_W && lane != 2'b00) ||
                (off >= 32'(WORDS * 4));

   assign req_ready = (state == ST_RUN);
   assign init_busy = (state == ST_CLEAR);
   assign acc       = req_valid && req_ready;

   assign be       = byte_en(req_size, lane);
   assign bit_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};

   always_comb begin
      wpos = req_wdata;
      case (req_size)
         SZ_B:    wpos = {4{req_wdata[7:0]}};
         SZ_H:    wpos = {2{req_wdata[15:0]}};
         default: wpos = req_wdata;
      endcase
   end

   assign cur    = mem[idx];
   assign merged = (cur & ~bit_mask) | (wpos & bit_mask);
   assign ld     = load_extract(cur, req_size, lane, req_signed);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_CLEAR;
         clr_idx <= '0;
      end else if (state == ST_CLEAR) begin
         clr_idx <= clr_idx + 1'b1;
         if (clr_idx == AW'(WORDS - 1)) state <= ST_RUN;
      end
   end

   // The array has no reset of its own; the clear FSM owns initialisation.
   always_ff @(posedge clk) begin
      if (state == ST_CLEAR) mem[clr_idx] <= '0;
      else if (acc && req_we && !err) mem[idx] <= merged;
   end

`ifdef DM_TRACE_EN
   always_ff @(posedge clk) begin
      if (acc && req_we && !err)
         $display("%0t@%08h: *%08h <= %08h", $time, req_pc, {req_addr[31:2], 2'b00}, merged);
   end
`else
   logic unused_pc;
   assign unused_pc = ^req_pc;
`endif

   dm_rsp_pipe #(.RD_LAT(RD_LAT)) u_rsp (
      .clk       (clk),
      .reset     (reset),
      .cap_valid (acc),
      .cap_err   (acc && err),
      .cap_rdata ((acc && !err && !req_we) ? ld : 32'h0),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata)
   );

endmodule

// File: tb/tb_dm_pipe.sv
// tb/tb_dm_pipe.sv - self-checking bench for dm_pipe against a byte-addressed reference model
module tb_dm_pipe;

   localparam int          WORDS  = 16;
   localparam int          RD_LAT = 3;
   localparam logic [31:0] BASE   = 32'h0000_0100;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_signed = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic [31:0] req_pc = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_busy;

   dm_pipe #(.WORDS(WORDS), .RD_LAT(RD_LAT), .BASE_ADDR(BASE)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_pc     (req_pc),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .init_busy  (init_busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] rdata;
      logic        err;
      logic        has_lit;
      logic [31:0] lit_rdata;
      logic        lit_err;
   } exp_t;

   exp_t        sb[$];
   logic [7:0]  mm [WORDS*4];
   int          cyc = 0;
   int          rel = 0;
   int          errs = 0;
   int          checks = 0;
   logic        lit_en = 1'b0;
   logic [31:0] lit_rd = 32'h0;
   logic        lit_er = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %08h expected %08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Byte-array view of memory: each request touches 1, 2 or 4 consecutive bytes.
   function automatic void model(input logic we, input logic [1:0] sz, input logic sgn,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 output logic [31:0] rd, output logic er);
      logic [31:0] o;
      logic [31:0] v;
      int nb;
      o  = addr - BASE;
      er = (sz == 2'd3) || (sz == 2'd1 && o[0]) || (sz == 2'd2 && o[1:0] != 2'b00) ||
           (o >= 32'(WORDS * 4));
      rd = 32'h0;
      if (!er) begin
         nb = 1 << sz;
         if (we) begin
            for (int i = 0; i < nb; i++) mm[int'(o) + i] = wd[8*i +: 8];
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = mm[int'(o) + i];
            if (sgn && sz == 2'd0) v = {{24{v[7]}}, v[7:0]};
            if (sgn && sz == 2'd1) v = {{16{v[15]}}, v[15:0]};
            rd = v;
         end
      end
   endfunction

   always @(posedge clk) begin
      exp_t e;
      cyc++;
      if (!reset) begin
         sb.delete();
         rel = 0;
         for (int i = 0; i < WORDS*4; i++) mm[i] = 8'h00;
      end else begin
         if (req_valid && rel >= WORDS) begin
            model(req_we, req_size, req_signed, req_addr, req_wdata, e.rdata, e.err);
            e.due       = cyc + RD_LAT - 1;
            e.has_lit   = lit_en;
            e.lit_rdata = lit_rd;
            e.lit_err   = lit_er;
            sb.push_back(e);
         end
         if (rel < WORDS) rel++;
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
         chk("rst_rsp_rdata", rsp_rdata, 32'h0);
         chk("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
         chk("rst_req_ready", {31'b0, req_ready}, 32'h0);
         chk("rst_init_busy", {31'b0, init_busy}, 32'h1);
      end else begin
         chk("req_ready", {31'b0, req_ready}, {31'b0, rel >= WORDS});
         chk("init_busy", {31'b0, init_busy}, {31'b0, rel < WORDS});
         if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
            if (e.has_lit) begin
               chk("pin_rdata", e.rdata, e.lit_rdata);
               chk("pin_err", {31'b0, e.err}, {31'b0, e.lit_err});
            end
         end else begin
            chk("rsp_idle", {31'b0, rsp_valid}, 32'h0);
         end
      end
   end

   task automatic rq(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] off,
                     input logic [31:0] wd, input logic [31:0] lr, input logic le);
      req_valid  = 1'b1;
      req_we     = we;
      req_size   = sz;
      req_signed = sg;
      req_addr   = BASE + off;
      req_wdata  = wd;
      req_pc     = 32'h0000_4000 + off;
      lit_en     = 1'b1;
      lit_rd     = lr;
      lit_er     = le;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lit_en    = 1'b0;
   endtask

   // Hold a load across the whole clear; it may only be accepted on edge WORDS+1.
   task automatic clear_then_load(input logic [31:0] off);
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_size   = 2'd2;
      req_signed = 1'b0;
      req_addr   = BASE + off;
      lit_en     = 1'b1;
      lit_rd     = 32'h0;
      lit_er     = 1'b0;
      repeat (WORDS + 1) @(posedge clk);
      #1;
      req_valid = 1'b0;
      lit_en    = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      clear_then_load(32'h0);

      rq(1, 2, 0, 32'h00, 32'h8000_FF7F, 32'h0, 0);
      rq(0, 0, 1, 32'h00, 32'h0, 32'h0000_007F, 0);
      rq(0, 0, 1, 32'h01, 32'h0, 32'hFFFF_FFFF, 0);
      rq(0, 0, 0, 32'h03, 32'h0, 32'h0000_0080, 0);
      rq(0, 1, 1, 32'h02, 32'h0, 32'hFFFF_8000, 0);
      rq(0, 1, 0, 32'h00, 32'h0, 32'h0000_FF7F, 0);

      rq(1, 2, 0, 32'h04, 32'h1122_3344, 32'h0, 0);
      rq(1, 0, 0, 32'h06, 32'h0000_00AA, 32'h0, 0);
      rq(1, 1, 0, 32'h04, 32'h0000_BEEF, 32'h0, 0);
      rq(0, 2, 0, 32'h04, 32'h0, 32'h11AA_BEEF, 0);

      rq(1, 1, 0, 32'h05, 32'h0000_1234, 32'h0, 1);
      rq(1, 2, 0, 32'h02, 32'hDEAD_BEEF, 32'h0, 1);
      rq(1, 3, 0, 32'h08, 32'hDEAD_BEEF, 32'h0, 1);
      rq(1, 2, 0, 32'h40, 32'hDEAD_BEEF, 32'h0, 1);
      rq(0, 2, 0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1);
      rq(0, 2, 0, 32'h04, 32'h0, 32'h11AA_BEEF, 0);
      rq(0, 2, 0, 32'h00, 32'h0, 32'h8000_FF7F, 0);
      rq(0, 2, 0, 32'h08, 32'h0, 32'h0, 0);

      rq(1, 2, 0, 32'h3C, 32'hCAFE_F00D, 32'h0, 0);
      rq(0, 2, 0, 32'h3C, 32'h0, 32'hCAFE_F00D, 0);
      rq(0, 1, 1, 32'h3E, 32'h0, 32'hFFFF_CAFE, 0);
      rq(0, 0, 0, 32'h3D, 32'h0, 32'h0000_00F0, 0);
      rq(0, 1, 0, 32'h3C, 32'h0, 32'h0000_F00D, 0);
      repeat (RD_LAT + 2) @(posedge clk);
      #1;

      rq(0, 2, 0, 32'h00, 32'h0, 32'h8000_FF7F, 0);
      rq(0, 2, 0, 32'h04, 32'h0, 32'h11AA_BEEF, 0);
      rq(0, 2, 0, 32'h3C, 32'h0, 32'hCAFE_F00D, 0);
      #1;
      chk("pre_drop_valid", {31'b0, rsp_valid}, 32'h1);
      #1 reset = 1'b0;
      #1;
      chk("async_drop_valid", {31'b0, rsp_valid}, 32'h0);
      chk("async_drop_ready", {31'b0, req_ready}, 32'h0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      clear_then_load(32'h04);
      rq(0, 2, 0, 32'h3C, 32'h0, 32'h0, 0);
      repeat (RD_LAT + 3) @(posedge clk);
      #1;

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
